// File: rtl/rip_fas_pkg.sv
// Shared definitions for the 4-bit ripple add/subtract accumulator.
package rip_fas_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_ADC  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rip_fas_acc_fasrip.sv
// 4-bit ripple-carry adder/subtractor: sum = a + (b ^ {s_op}) + cin.
module fasrip
  import rip_fas_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s_op,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff    = b ^ {WIDTH{s_op}};
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1]   = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  assign cout = carry[WIDTH];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/rip_fas_acc.sv
// Command-driven accumulator: IDLE captures a command, EXEC updates acc/flags,
// RESP holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a command; in_ready=1
// EXEC  | arithmetic on registered command, acc/c/v update at exit
// RESP  | result valid, held until out_ready
module rip_fas_acc
  import rip_fas_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_c,
  output logic             out_v
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic             alu_sub;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_cout;
  logic             alu_ovf;

  always_comb begin
    alu_sub = (op_q == OP_SUB);
    case (op_q)
      OP_ADC:  alu_cin = c_q;
      OP_SUB:  alu_cin = 1'b1;
      default: alu_cin = 1'b0;
    endcase
  end

  fasrip u_fasrip (
    .a    (acc_q),
    .b    (data_q),
    .s_op (alu_sub),
    .cin  (alu_cin),
    .sum  (alu_sum),
    .cout (alu_cout),
    .ovf  (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    acc_d   = acc_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          data_d  = in_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        if (op_q == OP_LOAD) begin
          acc_d = data_q;
          c_d   = 1'b0;
          v_d   = 1'b0;
        end else begin
          acc_d = alu_sum;
          // Subtraction carry-out means "no borrow", so invert it.
          c_d   = alu_sub ? ~alu_cout : alu_cout;
          v_d   = alu_ovf;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign out_acc   = acc_q;
  assign out_c     = c_q;
  assign out_v     = v_q;

endmodule

// File: doc/rip_fas_acc.md
RIP_FAS_ACC -- requirements
Module: rip_fas_acc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports are clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 in_valid  in  1  command present.
REQ-005 in_ready  out  1  block can accept a command this cycle.
REQ-006 in_op  in  2  opcode: 00 LOAD, 01 ADD, 10 ADC (add with carry), 11 SUB.
REQ-007 in_data  in  4  operand d.
REQ-008 out_valid  out  1  result present.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 out_acc  out  4  accumulator value after the command.
REQ-011 out_c  out  1  carry flag: carry-out for ADD/ADC, borrow for SUB, 0 for LOAD.
REQ-012 out_v  out  1  signed two's-complement overflow flag, 0 for LOAD.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid=1 captures in_op/in_data into registers and moves to EXEC.
REQ-015 EXEC: in_ready=0, out_valid=0; acc, c and v update on this edge from the registered command; next state RESP.
REQ-016 RESP: in_ready=0, out_valid=1; outputs stay stable until out_ready=1, then the next state is IDLE.
REQ-017 Accept-to-out_valid latency SHALL be 2 cycles; the minimum command period is 3 cycles with out_ready held at 1.
REQ-018 ADD: {c,acc} = acc + d, 5-bit result.
REQ-019 ADC: {c,acc} = acc + d + c_prev, where c_prev is the registered carry from the previous command.
REQ-020 SUB: acc = (acc - d) mod 16; c = 1 exactly when acc_old < d unsigned.
REQ-021 LOAD: acc = d; c = 0; v = 0.
REQ-022 v = 1 when both operands have the same sign bit and the result sign differs; for SUB, the effective second operand is -d.
REQ-023 Wrap-around: results are always modulo 16; the block SHALL never saturate.
REQ-024 in_valid while not in IDLE SHALL be ignored: no capture, and in_ready stays 0.
REQ-025 out_ready while not in RESP SHALL have no effect.
REQ-026 Undriven or X opcodes are not specified; the four defined encodings are the complete set.

Reset
REQ-027 While rst=1 the block SHALL hold: state=IDLE, acc=0, c=0, v=0, in_ready=1, out_valid=0, captured command registers=0.
REQ-028 rst asserted in EXEC or RESP SHALL abort the command: no result is delivered, and acc/flags return to 0.
REQ-029 The first rising clk edge after rst deasserts SHALL accept a command if in_valid=1.

Structure
REQ-030 A shared package rip_fas_pkg SHALL hold the opcode enum (OP_LOAD, OP_ADD, OP_ADC, OP_SUB), the FSM state enum, and the localparam WIDTH=4.
REQ-031 The arithmetic SHALL be one instance of the existing 4-bit ripple add/subtract sub-module fasrip, driven as follows:
- a = acc
- b = d
- s_op = 1 for SUB only
- cin chosen so that REQ-018 to REQ-020 hold
REQ-032 No other sub-modules; the FSM, registers and flag logic are in rip_fas_acc.

Verification
REQ-033 Reset, LOAD 3, then ADD 1 -> out_acc=4, out_c=0, out_v=0; out_valid is asserted 2 cycles after each accept.
REQ-034 LOAD 3, then SUB 1 -> out_acc=2, out_c=0.
REQ-035 LOAD 2, then SUB 3 -> out_acc=15, out_c=1, out_v=0.
REQ-036 LOAD 15, ADD 1 -> out_acc=0, out_c=1; then ADC 0 -> out_acc=1, out_c=0.
REQ-037 LOAD 7, ADD 1 -> out_acc=8, out_v=1.
REQ-038 Back-pressure:
- out_ready=0 for 5 cycles in RESP -> out_acc stays stable and in_ready stays 0.
- in_valid pulses during that window are not captured.
- rst during EXEC -> out_valid never rises, and out_acc=0 after reset.
